// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), frame-size helper and sequencer state type.
package vga_pkg;

    localparam int unsigned DEF_CNT_W  = 12;
    localparam int unsigned DEF_H_RES  = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_V_RES  = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } vga_state_e;

    function automatic int unsigned vga_h_total(input int unsigned res, input int unsigned fp,
                                                input int unsigned sync, input int unsigned bp);
        return res + fp + sync + bp;
    endfunction

    function automatic int unsigned vga_v_total(input int unsigned res, input int unsigned fp,
                                                input int unsigned sync, input int unsigned bp);
        return res + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_dly_line.sv
// Clock-enabled shift register with async active-low reset to INIT; DEPTH=0 is a wire.
module vga_dly_line #(
    parameter int unsigned      DEPTH = 2,
    parameter int unsigned      WIDTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             pxl_clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_bypass
        logic w_unused;
        assign w_unused = ^{pxl_clk, rst_n, i_en};
        assign o_q      = i_d;
    end else begin : g_pipe
        logic [WIDTH-1:0] r_pipe [DEPTH];

        always_ff @(posedge pxl_clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_pipe[i] <= INIT;
                end
            end else if (i_en) begin
                r_pipe[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        assign o_q = r_pipe[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: x/y counters, delayed syncs/DE, strobes and a
// run/stop sequencer that only starts or stops on frame boundaries.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned H_RES    = DEF_H_RES,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_RES    = DEF_V_RES,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic             pxl_clk,
    input  logic             rst_n,
    input  logic             pxl_clk_en,
    input  logic             run_i,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             req_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic             line_start_o,
    output logic             frame_start_o,
    output logic             busy_o
);

    localparam int unsigned H_TOTAL = vga_h_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_v_total(V_RES, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_BEG  = H_RES + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_RES + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    localparam bit CNT_W_OK  = (CNT_W >= 1) && (CNT_W <= 31);
    localparam longint unsigned CNT_SPAN = 64'd1 << (CNT_W_OK ? CNT_W : 1);
    localparam bit PARAMS_OK = CNT_W_OK && (H_RES >= 1) && (V_RES >= 1) && (PIPE_DLY <= 63)
                               && (64'(H_TOTAL) <= CNT_SPAN) && (64'(V_TOTAL) <= CNT_SPAN);

    if (!PARAMS_OK) begin : g_bad_params
        $fatal(1, "vga_timing_gen: illegal parameter set");
    end

    vga_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic [31:0]      w_x32, w_y32;
    logic             w_cnt, w_x_last, w_y_last;
    logic             w_act, w_hs, w_vs;
    logic [2:0]       w_stage, w_dly;

    assign w_x32 = 32'(r_x);
    assign w_y32 = 32'(r_y);

    // The IDLE tick that sees run_i is itself the (0,0) position of the first frame.
    assign w_cnt    = rst_n & ((r_state != StIdle) | run_i);
    assign w_x_last = (w_x32 == H_TOTAL - 1);
    assign w_y_last = (w_y32 == V_TOTAL - 1);

    assign w_act = w_cnt & (w_x32 < H_RES) & (w_y32 < V_RES);
    assign w_hs  = w_cnt & (w_x32 >= HS_BEG) & (w_x32 < HS_END);
    assign w_vs  = w_cnt & (w_y32 >= VS_BEG) & (w_y32 < VS_END);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        if (pxl_clk_en) begin
            if (w_cnt) begin
                if (w_x_last) begin
                    w_x_nxt = '0;
                    w_y_nxt = w_y_last ? '0 : r_y + 1'b1;
                end else begin
                    w_x_nxt = r_x + 1'b1;
                end
            end
            unique case (r_state)
                StIdle:  if (run_i) w_state_nxt = StRun;
                StRun:   if (!run_i) w_state_nxt = StDrain;
                StDrain: if (w_x_last && w_y_last) w_state_nxt = run_i ? StRun : StIdle;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    assign w_stage = {w_hs, w_vs, w_act};

    vga_dly_line #(
        .DEPTH (PIPE_DLY),
        .WIDTH (3),
        .INIT  (3'b000)
    ) u_dly (
        .pxl_clk (pxl_clk),
        .rst_n   (rst_n),
        .i_en    (pxl_clk_en),
        .i_d     (w_stage),
        .o_q     (w_dly)
    );

    assign x_o           = r_x;
    assign y_o           = r_y;
    assign req_o         = w_act;
    assign hsync_o       = w_dly[2] ~^ HS_POL;
    assign vsync_o       = w_dly[1] ~^ VS_POL;
    assign de_o          = w_dly[0];
    assign line_start_o  = pxl_clk_en & w_cnt & (r_x == '0);
    assign frame_start_o = line_start_o & (r_y == '0);
    assign busy_o        = (r_state != StIdle);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two small-raster instances (active-low syncs with
// two-tick delay, and active-high syncs with no delay) driven from shared stimulus.
module tb_vga_timing_gen;

    localparam int unsigned CW = 4;
    localparam int HT = 14;  // 8+2+2+2
    localparam int VT = 7;   // 4+1+1+1

    logic clk = 1'b0;
    logic rst_n, en, run;
    logic [CW-1:0] xa, ya, xb, yb;
    logic reqa, hsa, vsa, dea, lsa, fsa, busya;
    logic reqb, hsb, vsb, deb, lsb, fsb, busyb;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CNT_W (CW), .H_RES (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_RES (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b0), .VS_POL (1'b0), .PIPE_DLY (2)
    ) u_dut_a (
        .pxl_clk (clk), .rst_n (rst_n), .pxl_clk_en (en), .run_i (run),
        .x_o (xa), .y_o (ya), .req_o (reqa), .hsync_o (hsa), .vsync_o (vsa), .de_o (dea),
        .line_start_o (lsa), .frame_start_o (fsa), .busy_o (busya)
    );

    vga_timing_gen #(
        .CNT_W (CW), .H_RES (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_RES (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1), .PIPE_DLY (0)
    ) u_dut_b (
        .pxl_clk (clk), .rst_n (rst_n), .pxl_clk_en (en), .run_i (run),
        .x_o (xb), .y_o (yb), .req_o (reqb), .hsync_o (hsb), .vsync_o (vsb), .de_o (deb),
        .line_start_o (lsb), .frame_start_o (fsb), .busy_o (busyb)
    );

    typedef struct {
        logic [14:0] a;
        logic [14:0] b;
        bit          meas;
        bit          tick;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state (position seen before the coming edge).
    bit       m_busy, m_drain;
    int       mx, my;
    bit [2:0] m_d0, m_d1;
    bit       meas = 1'b0;
    int       cyc = 0;

    // Measurement tallies, counted on ticks only.
    int t_ticks, t_fs, t_de_a, t_hs_a, t_vs_a, t_busy, t_de_b, t_hs_b, t_vs_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_tally();
        t_ticks = 0; t_fs = 0; t_de_a = 0; t_hs_a = 0; t_vs_a = 0;
        t_busy = 0; t_de_b = 0; t_hs_b = 0; t_vs_b = 0;
    endtask

    task automatic push_exp();
        bit   cnt, act, hs, vs, ls, fs, wrap;
        exp_t e;
        if (!rst_n) begin
            m_busy = 0; m_drain = 0; mx = 0; my = 0; m_d0 = '0; m_d1 = '0;
        end
        cnt = rst_n && (m_busy || run);
        act = cnt && mx < 8 && my < 4;
        hs  = cnt && mx >= 10 && mx < 12;
        vs  = cnt && my == 5;
        ls  = en && cnt && mx == 0;
        fs  = ls && my == 0;
        e.a    = {4'(mx), 4'(my), act, ~m_d1[2], ~m_d1[1], m_d1[0], ls, fs, m_busy};
        e.b    = {4'(mx), 4'(my), act, hs, vs, act, ls, fs, m_busy};
        e.meas = meas;
        e.tick = en && rst_n;
        e.cyc  = cyc;
        q.push_back(e);
        cyc++;
        if (rst_n && en) begin
            wrap = (mx == HT - 1) && (my == VT - 1);
            m_d1 = m_d0;
            m_d0 = {hs, vs, act};
            if (cnt) begin
                if (mx == HT - 1) begin
                    mx = 0;
                    my = (my == VT - 1) ? 0 : my + 1;
                end else begin
                    mx++;
                end
            end
            if (!m_busy) begin
                if (run) begin m_busy = 1; m_drain = 0; end
            end else if (!m_drain) begin
                if (!run) m_drain = 1;
            end else if (wrap) begin
                if (run) m_drain = 0;
                else     m_busy  = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit ru, input bit e);
        @(negedge clk);
        rst_n = r;
        run   = ru;
        en    = e;
        #1;
        push_exp();
    endtask

    task automatic check_frame(input string name, input int ticks, input int fs, input int de,
                               input int hsl, input int vsl);
        #2;
        chk({name, "_ticks"}, t_ticks, ticks);
        chk({name, "_frame_starts"}, t_fs, fs);
        chk({name, "_de_a"}, t_de_a, de);
        chk({name, "_hsync_low_a"}, t_hs_a, hsl);
        chk({name, "_vsync_low_a"}, t_vs_a, vsl);
        chk({name, "_de_b"}, t_de_b, de);
        chk({name, "_hsync_high_b"}, t_hs_b, hsl);
        chk({name, "_vsync_high_b"}, t_vs_b, vsl);
        meas = 1'b0;
        clear_tally();
    endtask

    task automatic check_busy(input string name, input int ticks, input int fs, input int busy);
        #2;
        chk({name, "_ticks"}, t_ticks, ticks);
        chk({name, "_frame_starts"}, t_fs, fs);
        chk({name, "_busy_ticks"}, t_busy, busy);
        meas = 1'b0;
        clear_tally();
    endtask

    // Monitor: compares every queued expectation against both instances.
    initial begin
        exp_t        e;
        logic [14:0] aa, ab;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e  = q.pop_front();
                aa = {xa, ya, reqa, hsa, vsa, dea, lsa, fsa, busya};
                ab = {xb, yb, reqb, hsb, vsb, deb, lsb, fsb, busyb};
                chk($sformatf("cyc%0d_dut_a", e.cyc), 32'(aa), 32'(e.a));
                chk($sformatf("cyc%0d_dut_b", e.cyc), 32'(ab), 32'(e.b));
                if (e.meas && e.tick) begin
                    t_ticks++;
                    if (fsa)   t_fs++;
                    if (dea)   t_de_a++;
                    if (!hsa)  t_hs_a++;
                    if (!vsa)  t_vs_a++;
                    if (busya) t_busy++;
                    if (deb)   t_de_b++;
                    if (hsb)   t_hs_b++;
                    if (vsb)   t_vs_b++;
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        run   = 1'b1;
        en    = 1'b1;
        clear_tally();

        // Reset held with run requested: idle outputs, syncs inactive.
        repeat (3) step(1'b0, 1'b1, 1'b1);

        // Two continuous frames at full tick rate; frame_start on the first tick.
        meas = 1'b1;
        repeat (2 * HT * VT) step(1'b1, 1'b1, 1'b1);
        check_frame("full_rate", 196, 2, 64, 28, 28);

        // One tick in four: same counts measured in ticks, nothing moves in between.
        meas = 1'b1;
        repeat (2 * HT * VT) begin
            step(1'b1, 1'b1, 1'b1);
            repeat (3) step(1'b1, 1'b1, 1'b0);
        end
        check_frame("quarter_rate", 196, 2, 64, 28, 28);

        // Drop run mid-frame at (5,3): busy through the end of the frame, then idle.
        guard = 0;
        while (!(mx == 5 && my == 3) && guard < 200) begin
            step(1'b1, 1'b1, 1'b1);
            guard++;
        end
        chk("reach_drop_point", 32'(guard < 200), 32'd1);
        meas = 1'b1;
        repeat (60) step(1'b1, 1'b0, 1'b1);
        check_busy("drain_to_idle", 60, 0, 51);

        // Restart, drop, then reassert while draining: no gap, one start on schedule.
        guard = 0;
        while (!(mx == 5 && my == 3) && guard < 200) begin
            step(1'b1, 1'b1, 1'b1);
            guard++;
        end
        chk("reach_second_drop", 32'(guard < 200), 32'd1);
        repeat (10) step(1'b1, 1'b0, 1'b1);
        meas = 1'b1;
        repeat (HT * VT) step(1'b1, 1'b1, 1'b1);
        check_busy("drain_resume", 98, 1, 98);

        // Asynchronous reset between edges, mid-line.
        repeat (2) step(1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a", 32'({xa, ya, reqa, hsa, vsa, dea, lsa, fsa, busya}),
            32'({4'd0, 4'd0, 7'b0110000}));
        chk("async_rst_b", 32'({xb, yb, reqb, hsb, vsb, deb, lsb, fsb, busyb}), 32'd0);
        repeat (2) step(1'b0, 1'b1, 1'b1);
        meas = 1'b1;
        repeat (HT * VT) step(1'b1, 1'b1, 1'b1);
        check_frame("after_async_rst", 98, 1, 32, 14, 14);

        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the team's fixed 640x480 VGA sync/counter logic.
- Generates horizontal/vertical counters, sync pulses, data-enable and frame/line strobes for any resolution and sync polarity.
- Sync and data-enable are delayed by a configurable number of pixel ticks, so they line up with a downstream frame-buffer/palette fetch pipeline.
- Adds a run/stop state machine that only starts and stops at frame boundaries. Sits between the pixel-clock source and the frame buffer address counter/palette.

Parameters:
- CNT_W, 12, width of x/y counters; must satisfy H_TOTAL <= 2^CNT_W and V_TOTAL <= 2^CNT_W.
- H_RES, 640, active pixels per line.
- H_FP, 16, horizontal front porch (ticks).
- H_SYNC, 96, horizontal sync width (ticks).
- H_BP, 48, horizontal back porch (ticks).
- V_RES, 480, active lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- HS_POL, 0, hsync active level (0 = active-low).
- VS_POL, 0, vsync active level (0 = active-low).
- PIPE_DLY, 2, pixel ticks of delay applied to hsync_o/vsync_o/de_o relative to x_o/y_o/req_o; legal range 0..63.
- Derived: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP; V_TOTAL = V_RES+V_FP+V_SYNC+V_BP.

Ports:
- pxl_clk, in, 1, pixel clock; sole clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- pxl_clk_en, in, 1, pixel tick qualifier; all state advances only when high.
- run_i, in, 1, level request to generate frames.
- x_o, out, CNT_W, current horizontal count (counter stage).
- y_o, out, CNT_W, current vertical count (counter stage).
- req_o, out, 1, pixel fetch request: counter stage inside the active area.
- hsync_o, out, 1, delayed horizontal sync at HS_POL.
- vsync_o, out, 1, delayed vertical sync at VS_POL.
- de_o, out, 1, delayed data-enable.
- line_start_o, out, 1, one-cycle pulse on the tick where x=0 while running.
- frame_start_o, out, 1, one-cycle pulse on the tick where x=0 and y=0 while running.
- busy_o, out, 1, high in RUN or DRAIN.

Behaviour:
- Reset (async assert, release synchronous to pxl_clk):
  - state=IDLE; x=0, y=0; delay line filled with idle values.
  - Outputs: hsync_o=~HS_POL, vsync_o=~VS_POL, de_o=0, req_o=0, strobes=0, busy_o=0.
- Tick = pxl_clk edge with pxl_clk_en=1. Nothing changes on non-tick edges, including the delay line.
- State machine:
  - IDLE: on a tick with run_i=1 go to RUN. x=0/y=0 is the first counted position, so frame_start_o pulses on that same tick.
  - RUN: x increments per tick. At x=H_TOTAL-1, x wraps to 0 and y increments. At y=V_TOTAL-1 and x=H_TOTAL-1, both wrap to 0. If run_i=0 on any tick, go to DRAIN.
  - DRAIN: keep counting. On the wrap tick at (H_TOTAL-1, V_TOTAL-1): if run_i=1, return to RUN and continue seamlessly; otherwise go to IDLE with x=y=0.
  - Effect: frames are never truncated.
- In IDLE, counters hold at 0; req/de/strobes are 0 and syncs are inactive.
- Counter-stage combinational values (RUN/DRAIN only):
  - act = (x<H_RES)&(y<V_RES).
  - hs = (x>=H_RES+H_FP)&(x<H_RES+H_FP+H_SYNC).
  - vs = (y>=V_RES+V_FP)&(y<V_RES+V_FP+V_SYNC).
- req_o = act (zero latency w.r.t. x_o/y_o).
- hsync_o/vsync_o/de_o equal hs/vs/act from exactly PIPE_DLY ticks earlier, then mapped to polarity. PIPE_DLY=0: combinational from the counter stage, still polarity-mapped.
- Strobes are combinational from counter state, qualified by pxl_clk_en and busy.
- Comparisons are unsigned CNT_W-bit. Parameter sanity is checked at elaboration; an illegal set is a fatal error.
- rst_n asserted mid-frame: immediate return to the reset state. No partial-frame recovery.

Decomposition:
- Package vga_pkg: default 640x480@60 timing constants, derived H_TOTAL/V_TOTAL helper functions, state enum (IDLE, RUN, DRAIN).
- One sub-module, vga_dly_line: parametrised depth/width shift register with clock enable and async active-low reset to a parameter init value. Used for the {hs, vs, act} delay.

Test Plan:
- Reset: hold rst_n=0 with run_i=1 -> hsync_o=1, vsync_o=1, de_o=0, busy_o=0, x_o=y_o=0. Release -> frame_start_o pulses on the first tick.
- Default timing, run_i=1 for one frame, pxl_clk_en=1 -> exactly 800x525 ticks per frame. hsync_o low for 96 ticks starting at x=656+2. vsync_o low for lines 490-491. de_o high 640x480 ticks.
- pxl_clk_en toggling 1-of-4 -> all counts and durations identical when measured in ticks; no output changes on non-tick edges.
- Drop run_i at x=100, y=200 -> busy_o stays 1 until the wrap tick after (799,524), then IDLE. Reassert run_i during DRAIN -> no gap, next frame_start_o on schedule.
- HS_POL=1, VS_POL=1, PIPE_DLY=0, small timing (H 8/2/2/2, V 4/1/1/1) -> syncs active-high and coincident with x_o/y_o. Reset values hsync_o=0, vsync_o=0.
- Async reset asserted mid-line, between clock edges -> outputs reach reset values without a clock edge. Restart -> frame_start_o at x=0, y=0.
